// File: rtl/mac_pkg.sv
// Shared definitions for the Ethernet MAC datapath: transmit FSM states,
// framing constants and the CRC-32 parameters used on both TX and RX sides.
package mac_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREAMBLE = 3'd1,
        SFD      = 3'd2,
        DATA     = 3'd3,
        PAD      = 3'd4,
        FCS      = 3'd5,
        FLUSH    = 3'd6,
        IFG      = 3'd7
    } tx_state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam int          PREAMBLE_LEN  = 7;

    localparam int          BYTE_CNT_W    = 11;
    localparam logic [10:0] BYTE_CNT_MAX  = 11'h7FF;

    // Increment the frame byte counter, sticking at its maximum so that very
    // long frames never wrap back into the "needs padding" range.
    function automatic logic [10:0] sat_inc(input logic [10:0] v);
        if (v == BYTE_CNT_MAX) begin
            return v;
        end else begin
            return v + 11'd1;
        end
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// One-byte step of the reflected Ethernet CRC-32. Purely combinational so it
// can be shared by the transmit FCS generator and a receive-side checker.
module crc32_d8
    import mac_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [31:0] crc_out
);

    logic [31:0] c_s;

    // Fold the byte in LSB first, shifting out one bit per iteration.
    always_comb begin
        c_s = crc_in ^ {24'd0, data_in};
        for (int i = 0; i < 8; i++) begin
            if (c_s[0]) begin
                c_s = (c_s >> 1) ^ CRC_POLY;
            end else begin
                c_s = c_s >> 1;
            end
        end
        crc_out = c_s;
    end

endmodule

// File: rtl/rgmii_tx.sv
// RGMII transmit framer: wraps a payload byte stream with preamble, SFD,
// minimum-size padding and FCS, then enforces the inter-frame gap. Produces
// rise/fall nibbles and control bits for external DDR output registers.
module rgmii_tx
    import mac_pkg::*;
#(
    parameter int P_MIN_FRAME = 60,
    parameter int P_IFG       = 12
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [7:0] tx_data,
    input  logic       tx_data_valid,
    input  logic       tx_data_last,
    input  logic       tx_data_error,
    output logic       tx_data_ready,
    output logic [3:0] tx_rgmii_d_rise,
    output logic [3:0] tx_rgmii_d_fall,
    output logic       tx_rgmii_ctl_rise,
    output logic       tx_rgmii_ctl_fall
);

    localparam logic [10:0] MIN_CNT  = 11'(P_MIN_FRAME);
    localparam logic [15:0] IFG_LAST = 16'(P_IFG - 1);
    localparam logic [2:0]  PRE_LAST = 3'(PREAMBLE_LEN - 1);

    tx_state_t   state_r;
    logic [2:0]  pre_cnt_r;
    logic [1:0]  fcs_cnt_r;
    logic [15:0] ifg_cnt_r;
    logic [10:0] byte_cnt_r;
    logic [10:0] byte_cnt_inc_s;
    logic [31:0] crc_r;
    logic [31:0] crc_next_s;
    logic [31:0] fcs_word_s;
    logic [7:0]  crc_byte_s;
    logic [7:0]  fcs_byte_s;
    logic [7:0]  emit_byte_s;
    logic        emit_en_s;
    logic        emit_er_s;

    // Ready depends only on the registered state, never on tx_data_valid.
    assign tx_data_ready  = (state_r == DATA) || (state_r == FLUSH);
    assign byte_cnt_inc_s = sat_inc(byte_cnt_r);
    assign fcs_word_s     = ~crc_r;

    // Pad bytes enter the CRC as zeros; payload bytes come straight from input.
    always_comb begin
        if (state_r == DATA) begin
            crc_byte_s = tx_data;
        end else begin
            crc_byte_s = 8'h00;
        end
    end

    crc32_d8 u_crc32_d8 (
        .crc_in  (crc_r),
        .data_in (crc_byte_s),
        .crc_out (crc_next_s)
    );

    // Pick the FCS byte for the current position, low byte first.
    always_comb begin
        fcs_byte_s = 8'h00;
        case (fcs_cnt_r)
            2'd0:    fcs_byte_s = fcs_word_s[7:0];
            2'd1:    fcs_byte_s = fcs_word_s[15:8];
            2'd2:    fcs_byte_s = fcs_word_s[23:16];
            2'd3:    fcs_byte_s = fcs_word_s[31:24];
            default: fcs_byte_s = 8'h00;
        endcase
    end

    // Decide what goes on the wire at the next clock edge.
    always_comb begin
        emit_byte_s = 8'h00;
        emit_en_s   = 1'b0;
        emit_er_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (tx_data_valid) begin
                    emit_byte_s = PREAMBLE_BYTE;
                    emit_en_s   = 1'b1;
                end else begin
                    emit_byte_s = 8'h00;
                    emit_en_s   = 1'b0;
                end
            end
            PREAMBLE: begin
                emit_byte_s = PREAMBLE_BYTE;
                emit_en_s   = 1'b1;
            end
            SFD: begin
                emit_byte_s = SFD_BYTE;
                emit_en_s   = 1'b1;
            end
            DATA: begin
                if (tx_data_valid) begin
                    emit_byte_s = tx_data;
                    emit_en_s   = 1'b1;
                    emit_er_s   = tx_data_error;
                end else begin
                    // Underrun: poison the frame so the link partner drops it.
                    emit_byte_s = 8'h00;
                    emit_en_s   = 1'b1;
                    emit_er_s   = 1'b1;
                end
            end
            PAD: begin
                emit_byte_s = 8'h00;
                emit_en_s   = 1'b1;
            end
            FCS: begin
                emit_byte_s = fcs_byte_s;
                emit_en_s   = 1'b1;
            end
            FLUSH:   emit_en_s = 1'b0;
            IFG:     emit_en_s = 1'b0;
            default: emit_en_s = 1'b0;
        endcase
    end

    // Framing FSM with its counters, running CRC and registered RGMII outputs.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_r           <= IDLE;
            pre_cnt_r         <= 3'd0;
            fcs_cnt_r         <= 2'd0;
            ifg_cnt_r         <= 16'd0;
            byte_cnt_r        <= 11'd0;
            crc_r             <= CRC_INIT;
            tx_rgmii_d_rise   <= 4'd0;
            tx_rgmii_d_fall   <= 4'd0;
            tx_rgmii_ctl_rise <= 1'b0;
            tx_rgmii_ctl_fall <= 1'b0;
        end else begin
            tx_rgmii_d_rise   <= emit_byte_s[3:0];
            tx_rgmii_d_fall   <= emit_byte_s[7:4];
            tx_rgmii_ctl_rise <= emit_en_s;
            tx_rgmii_ctl_fall <= emit_en_s ^ emit_er_s;
            case (state_r)
                IDLE: begin
                    fcs_cnt_r <= 2'd0;
                    if (tx_data_valid) begin
                        state_r   <= PREAMBLE;
                        pre_cnt_r <= 3'd1;
                    end
                end
                PREAMBLE: begin
                    if (pre_cnt_r == PRE_LAST) begin
                        state_r <= SFD;
                    end else begin
                        pre_cnt_r <= pre_cnt_r + 3'd1;
                    end
                end
                SFD: begin
                    state_r    <= DATA;
                    crc_r      <= CRC_INIT;
                    byte_cnt_r <= 11'd0;
                end
                DATA: begin
                    if (tx_data_valid) begin
                        crc_r      <= crc_next_s;
                        byte_cnt_r <= byte_cnt_inc_s;
                        if (tx_data_last) begin
                            fcs_cnt_r <= 2'd0;
                            state_r   <= (byte_cnt_inc_s < MIN_CNT) ? PAD : FCS;
                        end
                    end else begin
                        state_r <= FLUSH;
                    end
                end
                PAD: begin
                    crc_r      <= crc_next_s;
                    byte_cnt_r <= byte_cnt_inc_s;
                    fcs_cnt_r  <= 2'd0;
                    if (byte_cnt_inc_s >= MIN_CNT) begin
                        state_r <= FCS;
                    end
                end
                FCS: begin
                    if (fcs_cnt_r == 2'd3) begin
                        state_r   <= IFG;
                        ifg_cnt_r <= 16'd0;
                    end else begin
                        fcs_cnt_r <= fcs_cnt_r + 2'd1;
                    end
                end
                FLUSH: begin
                    if (tx_data_valid && tx_data_last) begin
                        state_r   <= IFG;
                        ifg_cnt_r <= 16'd0;
                    end
                end
                IFG: begin
                    if (ifg_cnt_r == IFG_LAST) begin
                        state_r <= IDLE;
                    end else begin
                        ifg_cnt_r <= ifg_cnt_r + 16'd1;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule
